board_level_frame_packer: RTL and testbench

Parametrised framing and width-conversion front end for the board-level serial link. It accepts a framed stream of IN_W-bit words over a valid/ready handshake and emits a stream of OUT_W-bit symbols, with explicit start-of-frame and end-of-frame marker beats. It optionally appends a CRC-8/MAXIM trailer and zero-pads the last symbol. It generalises the fixed 8-to-6 transmitter front end to arbitrary widths, adds back-pressure on both sides, and enforces a maximum frame length. Its output feeds the physical serializer stage.

---
 rtl/board_level_frame_packer_if.sv | 26 ++
 rtl/board_level_frame_packer.sv | 142 ++++++++++++++
 tb/tb_board_level_frame_packer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_level_frame_packer_if.sv
// Stream bundle for the frame packer: IN_W-bit framed words in, OUT_W-bit marked symbols out.
// The master side drives words and downstream ready; the slave side is the packer itself.
interface board_level_frame_packer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 6
);
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_sof;
  logic             m_eof;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eof
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eof
  );
endinterface

// File: rtl/board_level_frame_packer.sv
// Framing and width conversion for the board-level serial link: SOF marker, MSB-first
// repacked payload, optional CRC-8/MAXIM trailer, zero-padded last symbol, EOF marker.
module board_level_frame_packer #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 6,
  parameter int CRC_EN    = 1,
  parameter int MAX_WORDS = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  board_level_frame_packer_if.slave bus,
  output logic                      frame_err,
  output logic                      busy
);
  localparam int BYTE_W = (IN_W > 8) ? IN_W : 8;
  localparam int ACC_W  = 2 * OUT_W - 1 + BYTE_W;
  localparam int CNT_W  = $clog2(ACC_W + 1);
  localparam int WC_W   = $clog2(MAX_WORDS + 1);

  localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] OUT2_C  = CNT_W'(2 * OUT_W);
  localparam logic [CNT_W-1:0] IN_C    = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] BYTE_C  = CNT_W'(8);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MAX_WORDS - 1);

  if ((CRC_EN != 0 && (IN_W % 8) != 0) || IN_W < 1 || IN_W > 16 ||
      OUT_W < 1 || OUT_W > 16 || MAX_WORDS < 1) begin : g_bad_cfg
    $error("board_level_frame_packer: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, SOF, DATA, CRC, PAD, EOF} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next, acc_after, ins;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_after, ins_len;
  logic [WC_W-1:0]  wcnt, wcnt_next;
  logic [7:0]       crc, crc_next;
  logic             frame_err_next;
  logic             m_valid_i;
  logic             pop;
  logic             clear;

  // Reflected CRC-8/MAXIM (poly 0x31, init 0), bytes folded most significant first.
  function automatic logic [7:0] crc_word(input logic [7:0] c, input logic [IN_W-1:0] w);
    logic [15:0] wx;
    logic [7:0]  r;
    wx = 16'(w);
    r  = c;
    for (int b = IN_W / 8 - 1; b >= 0; b--) begin
      r = r ^ wx[b*8 +: 8];
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    end
    return r;
  endfunction

  // Beat presentation is a pure function of registered state so nothing from s_* leaks out.
  always_comb begin
    case (state)
      SOF, EOF:  m_valid_i = 1'b1;
      DATA, CRC: m_valid_i = (cnt >= OUT_C);
      PAD:       m_valid_i = (cnt != '0);
      default:   m_valid_i = 1'b0;
    endcase
  end

  assign bus.m_valid = m_valid_i;
  assign bus.m_data  = (state inside {DATA, CRC, PAD}) ? acc[ACC_W-1 -: OUT_W] : '0;
  assign bus.m_sof   = (state == SOF);
  assign bus.m_eof   = (state == EOF);
  assign busy        = (state != IDLE);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    state_next     = state;
    wcnt_next      = wcnt;
    crc_next       = crc;
    frame_err_next = frame_err;
    bus.s_ready    = 1'b0;
    pop            = m_valid_i && bus.m_ready && (state inside {DATA, CRC, PAD});
    ins            = '0;
    ins_len        = '0;
    clear          = 1'b0;

    case (state)
      IDLE: if (bus.s_valid) begin
        state_next     = SOF;
        clear          = 1'b1;
        wcnt_next      = '0;
        crc_next       = '0;
        frame_err_next = 1'b0;
      end
      SOF: if (bus.m_ready) state_next = DATA;
      DATA: begin
        bus.s_ready = (cnt < OUT_C) || ((cnt < OUT2_C) && bus.m_ready);
        if (bus.s_valid && bus.s_ready) begin
          ins       = ACC_W'(bus.s_data) << (ACC_W - IN_W);
          ins_len   = IN_C;
          wcnt_next = wcnt + WC_W'(1);
          if (CRC_EN != 0) crc_next = crc_word(crc, bus.s_data);
          if (bus.s_last || wcnt == WC_LAST) begin
            state_next = (CRC_EN != 0) ? CRC : PAD;
            if (!bus.s_last) frame_err_next = 1'b1;
          end
        end
      end
      CRC: if (cnt < OUT_C) begin
        ins        = ACC_W'(crc) << (ACC_W - 8);
        ins_len    = BYTE_C;
        state_next = PAD;
      end
      PAD:     if (cnt == '0) state_next = EOF;
      EOF:     if (bus.m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Pop first, then drop new bits in directly behind whatever remains; a partial
    // final symbol in PAD is flushed whole because the bits below cnt are always zero.
    cnt_after = pop ? ((cnt >= OUT_C) ? cnt - OUT_C : '0) : cnt;
    acc_after = pop ? (acc << OUT_W) : acc;
    acc_next  = clear ? '0 : (acc_after | (ins >> cnt_after));
    cnt_next  = clear ? '0 : (cnt_after + ins_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      wcnt      <= '0;
      crc       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      wcnt      <= wcnt_next;
      crc       <= crc_next;
      frame_err <= frame_err_next;
    end
  end
endmodule

// File: tb/tb_board_level_frame_packer.sv
// Directed bench for board_level_frame_packer: three configurations (8->6 plain with a
// 4-word cap, 8->6 with CRC, 16->5 with CRC under random back-pressure).
module tb_board_level_frame_packer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  board_level_frame_packer_if #(.IN_W(8),  .OUT_W(6)) ifa ();
  board_level_frame_packer_if #(.IN_W(8),  .OUT_W(6)) ifb ();
  board_level_frame_packer_if #(.IN_W(16), .OUT_W(5)) ifc ();
  logic fe_a, busy_a, fe_b, busy_b, fe_c, busy_c;

  board_level_frame_packer #(.IN_W(8), .OUT_W(6), .CRC_EN(0), .MAX_WORDS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .frame_err(fe_a), .busy(busy_a));
  board_level_frame_packer #(.IN_W(8), .OUT_W(6), .CRC_EN(1), .MAX_WORDS(1024)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .frame_err(fe_b), .busy(busy_b));
  board_level_frame_packer #(.IN_W(16), .OUT_W(5), .CRC_EN(1), .MAX_WORDS(1024)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .frame_err(fe_c), .busy(busy_c));

  // Beats are encoded as 'h100|data for SOF, 'h200|data for EOF, plain data otherwise.
  logic [7:0] wq[$];
  int         got_q[$];
  int         eq[$];

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = r >> 1;
      if (fb) r = r ^ 8'h8C;
    end
    return r;
  endfunction

  task automatic run_a(input bit use_last, input int budget, output int accepted);
    int idx;
    bit done;
    idx = 0; done = 1'b0; accepted = 0;
    got_q.delete();
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      ifa.m_ready = 1'b1;
      ifa.s_valid = (idx < wq.size());
      ifa.s_last  = 1'b0;
      if (idx < wq.size()) begin
        ifa.s_data = wq[idx];
        ifa.s_last = use_last && (idx == wq.size() - 1);
      end
      #1;
      if (ifa.m_valid) begin
        got_q.push_back({22'd0, ifa.m_eof, ifa.m_sof, 2'b00, ifa.m_data});
        done = ifa.m_eof;
      end
      if (ifa.s_valid && ifa.s_ready) begin idx++; accepted++; end
    end
    ifa.s_valid = 1'b0;
    ifa.s_last  = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL run_a timeout: no EOF within %0d cycles", budget); end
  endtask

  task automatic run_b(input int budget);
    int idx;
    bit done;
    idx = 0; done = 1'b0;
    got_q.delete();
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clk);
      ifb.m_ready = 1'b1;
      ifb.s_valid = (idx < wq.size());
      ifb.s_last  = 1'b0;
      if (idx < wq.size()) begin
        ifb.s_data = wq[idx];
        ifb.s_last = (idx == wq.size() - 1);
      end
      #1;
      if (ifb.m_valid) begin
        got_q.push_back({22'd0, ifb.m_eof, ifb.m_sof, 2'b00, ifb.m_data});
        done = ifb.m_eof;
      end
      if (ifb.s_valid && ifb.s_ready) idx++;
    end
    ifb.s_valid = 1'b0;
    ifb.s_last  = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL run_b timeout: no EOF within %0d cycles", budget); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    {ifa.s_valid, ifa.s_last, ifa.m_ready, ifa.s_data} = '0;
    {ifb.s_valid, ifb.s_last, ifb.m_ready, ifb.s_data} = '0;
    {ifc.s_valid, ifc.s_last, ifc.m_ready, ifc.s_data} = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.s_ready, ifa.m_valid, ifa.m_data, ifa.m_sof, ifa.m_eof, fe_a, busy_a} !== 12'd0) begin
      errors++; $display("FAIL reset_a outputs: got %b required all zero",
        {ifa.s_ready, ifa.m_valid, ifa.m_data, ifa.m_sof, ifa.m_eof, fe_a, busy_a});
    end
    checks++;
    if ({ifb.s_ready, ifb.m_valid, ifb.m_data, ifb.m_sof, ifb.m_eof, fe_b, busy_b} !== 12'd0) begin
      errors++; $display("FAIL reset_b outputs: got %b required all zero",
        {ifb.s_ready, ifb.m_valid, ifb.m_data, ifb.m_sof, ifb.m_eof, fe_b, busy_b});
    end
    checks++;
    if ({ifc.s_ready, ifc.m_valid, ifc.m_data, ifc.m_sof, ifc.m_eof, fe_c, busy_c} !== 11'd0) begin
      errors++; $display("FAIL reset_c outputs: got %b required all zero",
        {ifc.s_ready, ifc.m_valid, ifc.m_data, ifc.m_sof, ifc.m_eof, fe_c, busy_c});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int acc_n;
    wq.delete(); wq.push_back(8'hFF); wq.push_back(8'h00); wq.push_back(8'hAA);
    eq.delete(); eq.push_back('h100); eq.push_back('h3F); eq.push_back('h30);
    eq.push_back('h02); eq.push_back('h2A); eq.push_back('h200);
    run_a(1'b1, 50, acc_n);
    checks++;
    if (got_q.size() != eq.size()) begin
      errors++; $display("FAIL basic beat count: got %0d required %0d", got_q.size(), eq.size());
    end else foreach (eq[i]) begin
      checks++;
      if (got_q[i] !== eq[i]) begin
        errors++; $display("FAIL basic beat %0d: got 0x%0h required 0x%0h", i, got_q[i], eq[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL basic busy after EOF: got %b required 0", busy_a); end
  endtask

  task automatic test_pad();
    int acc_n;
    wq.delete(); wq.push_back(8'hA5);
    eq.delete(); eq.push_back('h100); eq.push_back('h29); eq.push_back('h10); eq.push_back('h200);
    run_a(1'b1, 50, acc_n);
    checks++;
    if (got_q.size() != eq.size()) begin
      errors++; $display("FAIL pad beat count: got %0d required %0d", got_q.size(), eq.size());
    end else foreach (eq[i]) begin
      checks++;
      if (got_q[i] !== eq[i]) begin
        errors++; $display("FAIL pad beat %0d: got 0x%0h required 0x%0h", i, got_q[i], eq[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_max_len();
    int acc_n;
    wq.delete();
    for (int k = 0; k < 6; k++) wq.push_back(8'h11 * (k + 1));
    eq.delete(); eq.push_back('h100); eq.push_back('h04); eq.push_back('h12); eq.push_back('h08);
    eq.push_back('h33); eq.push_back('h11); eq.push_back('h00); eq.push_back('h200);
    run_a(1'b0, 60, acc_n);
    checks++;
    if (acc_n !== 4) begin errors++; $display("FAIL max_len accepted words: got %0d required 4", acc_n); end
    checks++;
    if (got_q.size() != eq.size()) begin
      errors++; $display("FAIL max_len beat count: got %0d required %0d", got_q.size(), eq.size());
    end else foreach (eq[i]) begin
      checks++;
      if (got_q[i] !== eq[i]) begin
        errors++; $display("FAIL max_len beat %0d: got 0x%0h required 0x%0h", i, got_q[i], eq[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (fe_a !== 1'b1) begin errors++; $display("FAIL max_len frame_err in idle: got %b required 1", fe_a); end
    // Start the next frame with downstream stalled so the SOF beat can be inspected.
    ifa.m_ready = 1'b0; ifa.s_valid = 1'b1; ifa.s_data = 8'hA5; ifa.s_last = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({fe_a, ifa.m_sof, ifa.m_valid} !== 3'b011) begin
      errors++; $display("FAIL max_len frame_err clear at SOF: got fe/sof/valid=%b required 011",
        {fe_a, ifa.m_sof, ifa.m_valid});
    end
    wq.delete(); wq.push_back(8'hA5);
    eq.delete(); eq.push_back('h100); eq.push_back('h29); eq.push_back('h10); eq.push_back('h200);
    run_a(1'b1, 50, acc_n);
    checks++;
    if (got_q.size() != eq.size()) begin
      errors++; $display("FAIL max_len next frame count: got %0d required %0d", got_q.size(), eq.size());
    end else foreach (eq[i]) begin
      checks++;
      if (got_q[i] !== eq[i]) begin
        errors++; $display("FAIL max_len next beat %0d: got 0x%0h required 0x%0h", i, got_q[i], eq[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_crc_zero();
    wq.delete(); wq.push_back(8'h00);
    eq.delete(); eq.push_back('h100); eq.push_back('h00); eq.push_back('h00);
    eq.push_back('h00); eq.push_back('h200);
    run_b(50);
    checks++;
    if (got_q.size() != eq.size()) begin
      errors++; $display("FAIL crc_zero beat count: got %0d required %0d", got_q.size(), eq.size());
    end else foreach (eq[i]) begin
      checks++;
      if (got_q[i] !== eq[i]) begin
        errors++; $display("FAIL crc_zero beat %0d: got 0x%0h required 0x%0h", i, got_q[i], eq[i]);
      end
    end
    @(negedge clk);
  endtask

  // "123456789" has the published CRC-8/MAXIM check value 0xA1; 80 bits -> 14 symbols.
  task automatic test_crc_check();
    bit         bq[$];
    logic [7:0] rx, byte_v;
    int         bad;
    wq.delete();
    for (int k = 0; k < 9; k++) wq.push_back(8'h31 + 8'(k));
    run_b(100);
    checks++;
    if (got_q.size() != 16 || got_q[0] !== 'h100 || got_q[15] !== 'h200) begin
      errors++; $display("FAIL crc_check framing: got %0d beats required 16 with SOF/EOF ends", got_q.size());
    end else begin
      for (int i = 1; i < 15; i++)
        for (int b = 5; b >= 0; b--) bq.push_back(got_q[i][b]);
      bad = 0;
      for (int k = 0; k < 9; k++) begin
        byte_v = '0;
        for (int b = 0; b < 8; b++) byte_v = {byte_v[6:0], bq[k*8 + b]};
        if (byte_v !== 8'h31 + 8'(k)) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL crc_check payload: got %0d bad bytes required 0", bad); end
      rx = '0;
      for (int b = 0; b < 8; b++) rx = {rx[6:0], bq[72 + b]};
      checks++;
      if (rx !== 8'hA1) begin errors++; $display("FAIL crc_check trailer: got 0x%0h required 0xa1", rx); end
      checks++;
      if ({bq[80], bq[81], bq[82], bq[83]} !== 4'b0000) begin
        errors++; $display("FAIL crc_check pad bits: got %b required 0000", {bq[80], bq[81], bq[82], bq[83]});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w[$];
    bit          bq[$];
    int          exp_q[$];
    logic [7:0]  c;
    logic [6:0]  held;
    int          stall_err, n, idx, s;
    bit          done, hold, mism;
    stall_err = 0;
    for (int f = 0; f < 100; f++) begin
      w.delete(); bq.delete(); exp_q.delete(); got_q.delete();
      c = '0;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        w.push_back(16'($urandom));
        c = crc8_byte(c, w[k][15:8]);
        c = crc8_byte(c, w[k][7:0]);
        for (int b = 15; b >= 0; b--) bq.push_back(w[k][b]);
      end
      for (int b = 7; b >= 0; b--) bq.push_back(c[b]);
      while (bq.size() % 5 != 0) bq.push_back(1'b0);
      exp_q.push_back('h100);
      for (int i = 0; i < bq.size(); i += 5) begin
        s = 0;
        for (int j = 0; j < 5; j++) s = (s << 1) | int'(bq[i + j]);
        exp_q.push_back(s);
      end
      exp_q.push_back('h200);

      idx = 0; done = 1'b0; hold = 1'b0; held = '0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
        @(negedge clk);
        ifc.m_ready = ($urandom_range(0, 1) == 1);
        ifc.s_valid = (idx < n) && ($urandom_range(0, 3) != 0);
        if (idx < n) begin
          ifc.s_data = w[idx];
          ifc.s_last = (idx == n - 1);
        end
        #1;
        if (hold && (!ifc.m_valid || {ifc.m_sof, ifc.m_eof, ifc.m_data} !== held)) stall_err++;
        hold = ifc.m_valid && !ifc.m_ready;
        held = {ifc.m_sof, ifc.m_eof, ifc.m_data};
        if (ifc.m_valid && ifc.m_ready) begin
          got_q.push_back({22'd0, ifc.m_eof, ifc.m_sof, 3'b000, ifc.m_data});
          done = ifc.m_eof;
        end
        if (ifc.s_valid && ifc.s_ready) idx++;
      end
      ifc.s_valid = 1'b0;
      ifc.s_last  = 1'b0;
      mism = (got_q.size() != exp_q.size());
      if (!mism) foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) mism = 1'b1;
      checks++;
      if (mism || !done) begin
        errors++; $display("FAIL random frame %0d: got %0d beats (eof=%b) required %0d matching beats",
          f, got_q.size(), done, exp_q.size());
      end
    end
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL random stall stability: got %0d changes required 0", stall_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found;
    int acc_n;
    found = 1'b0;
    ifa.m_ready = 1'b1; ifa.s_valid = 1'b1; ifa.s_data = 8'hFF; ifa.s_last = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      @(negedge clk);
      #1;
      found = ifa.m_valid && !ifa.m_sof && busy_a;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid: no data beat within 10 cycles"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.s_ready, ifa.m_valid, ifa.m_data, ifa.m_sof, ifa.m_eof, fe_a, busy_a} !== 12'd0) begin
      errors++; $display("FAIL reset_mid outputs: got %b required all zero",
        {ifa.s_ready, ifa.m_valid, ifa.m_data, ifa.m_sof, ifa.m_eof, fe_a, busy_a});
    end
    ifa.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq.delete(); wq.push_back(8'hA5);
    eq.delete(); eq.push_back('h100); eq.push_back('h29); eq.push_back('h10); eq.push_back('h200);
    run_a(1'b1, 50, acc_n);
    checks++;
    if (got_q.size() != eq.size()) begin
      errors++; $display("FAIL reset_mid next frame count: got %0d required %0d", got_q.size(), eq.size());
    end else foreach (eq[i]) begin
      checks++;
      if (got_q[i] !== eq[i]) begin
        errors++; $display("FAIL reset_mid beat %0d: got 0x%0h required 0x%0h", i, got_q[i], eq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_max_len();
    test_crc_zero();
    test_crc_check();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
